mem_stage: RTL and testbench

Memory-access pipeline stage of the five-stage CPU, sitting between the execute stage and the write-back stage. It accepts one instruction at a time from EX and waits for the data-SRAM response of any load or store EX issued. It extracts and sign/zero-extends load data and hands a 168-bit bus to WB. It also drives bypass and stall information to decode and honours WB's exception/ertn flush.

---
 rtl/mem_stage_if.sv | 19 +
 rtl/mem_stage.sv | 135 +++++++++++++
 tb/tb_mem_stage.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Handshake and data bundle linking EX -> MS -> WB around the memory-access stage.
interface mem_stage_if;
    logic         es_to_ms_valid;
    logic [174:0] es_to_ms_bus;
    logic         ms_allowin;
    logic         ms_to_ws_valid;
    logic [167:0] ms_to_ws_bus;
    logic         ws_allowin;

    modport slave (
        input  es_to_ms_valid, es_to_ms_bus, ws_allowin,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus
    );

    modport master (
        output es_to_ms_valid, es_to_ms_bus, ws_allowin,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for the data-SRAM response, extracts load
// data, forwards to WB, and discards responses that belong to flushed instructions.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  pipe,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        ws_reflush_ms,
    output logic [4:0]  ms_to_ds_dest,
    output logic [31:0] ms_to_ds_value,
    output logic        ms_to_ds_load_wait,
    output logic        ms_csr,
    output logic        ms_ex
);

    logic         ms_valid_r;
    logic [174:0] bus_r;
    logic [1:0]   drop_cnt_r;
    logic         buf_valid_r;
    logic [31:0]  buf_data_r;

    logic         mem_req_s;
    logic         res_from_mem_s;
    logic [4:0]   load_op_s;
    logic [1:0]   addr_low_s;
    logic         discard_s;
    logic         owned_ok_s;
    logic         ready_go_s;
    logic         to_ws_valid_s;
    logic         allowin_s;
    logic         leave_s;
    logic         capture_s;
    logic         drop_inc_s;
    logic [1:0]   drop_cnt_nxt_s;
    logic [31:0]  word_s;
    logic [31:0]  final_s;
    logic [4:0]   dest_s;

    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [4:0]  op,
        input logic [1:0]  off
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        case (off)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = off[1] ? word[31:16] : word[15:0];
        case (op)
            5'b00001: res = {{24{byte_v[7]}}, byte_v};
            5'b00010: res = {24'd0, byte_v};
            5'b00100: res = {{16{half_v[15]}}, half_v};
            5'b01000: res = {16'd0, half_v};
            5'b10000: res = word;
            default:  res = word;
        endcase
        return res;
    endfunction

    assign mem_req_s      = bus_r[174];
    assign res_from_mem_s = bus_r[173];
    assign load_op_s      = bus_r[172:168];
    assign addr_low_s     = bus_r[137:136];

    // A response is discarded while older flushed requests are still owed one.
    assign discard_s  = data_sram_data_ok & (drop_cnt_r != 2'd0);
    assign owned_ok_s = data_sram_data_ok & (drop_cnt_r == 2'd0) &
                        ms_valid_r & mem_req_s & ~buf_valid_r;

    assign ready_go_s    = ~mem_req_s | buf_valid_r | (data_sram_data_ok & (drop_cnt_r == 2'd0));
    assign to_ws_valid_s = ms_valid_r & ready_go_s;
    assign allowin_s     = ~ms_valid_r | (ready_go_s & pipe.ws_allowin);
    assign leave_s       = to_ws_valid_s & pipe.ws_allowin;
    assign capture_s     = pipe.es_to_ms_valid & allowin_s & ~ws_reflush_ms;
    assign drop_inc_s    = ws_reflush_ms & ms_valid_r & mem_req_s & ~buf_valid_r & ~owned_ok_s;

    assign word_s  = buf_valid_r ? buf_data_r : data_sram_rdata;
    assign final_s = res_from_mem_s ? load_extract(word_s, load_op_s, addr_low_s) : bus_r[63:32];
    assign dest_s  = (ms_valid_r & bus_r[69]) ? bus_r[68:64] : 5'd0;

    assign pipe.ms_allowin     = allowin_s;
    assign pipe.ms_to_ws_valid = to_ws_valid_s;
    assign pipe.ms_to_ws_bus   = {bus_r[167:64], final_s, bus_r[31:0]};

    assign ms_to_ds_dest      = dest_s;
    assign ms_to_ds_value     = (dest_s != 5'd0) ? final_s : 32'd0;
    assign ms_to_ds_load_wait = ms_valid_r & res_from_mem_s & ~ready_go_s;
    assign ms_csr             = ms_valid_r & (bus_r[134] | bus_r[133]);
    assign ms_ex              = ms_valid_r & (bus_r[135] | (bus_r[86:70] != 17'd0));

    // Next discard count; simultaneous increment and decrement cancel out.
    always_comb begin
        drop_cnt_nxt_s = drop_cnt_r;
        case ({drop_inc_s, discard_s})
            2'b10:   drop_cnt_nxt_s = (drop_cnt_r == 2'd2) ? 2'd2 : drop_cnt_r + 2'd1;
            2'b01:   drop_cnt_nxt_s = drop_cnt_r - 2'd1;
            default: drop_cnt_nxt_s = drop_cnt_r;
        endcase
    end

    // Stage state: occupancy, captured bus, response buffer and discard count.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_r  <= 1'b0;
            bus_r       <= {175{1'b0}};
            drop_cnt_r  <= 2'd0;
            buf_valid_r <= 1'b0;
            buf_data_r  <= 32'd0;
        end else begin
            if (ws_reflush_ms) begin
                ms_valid_r <= 1'b0;
            end else if (allowin_s) begin
                ms_valid_r <= pipe.es_to_ms_valid;
            end

            if (capture_s) begin
                bus_r       <= pipe.es_to_ms_bus;
                buf_valid_r <= 1'b0;
            end else if (owned_ok_s && !leave_s) begin
                buf_valid_r <= 1'b1;
                buf_data_r  <= data_sram_rdata;
            end

            drop_cnt_r <= drop_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases followed by a randomized run
// scored against a transaction-level model of in-order SRAM responses.
module tb_mem_stage;

    typedef struct {
        logic [174:0] bus;
        logic [31:0]  data;
        logic         got;
    } inst_t;

    typedef struct {
        int          ready;
        logic [31:0] data;
        logic        alive;
    } resp_t;

    localparam logic [4:0] LD_B  = 5'b00001;
    localparam logic [4:0] LD_BU = 5'b00010;
    localparam logic [4:0] LD_H  = 5'b00100;
    localparam logic [4:0] LD_HU = 5'b01000;
    localparam logic [4:0] LD_W  = 5'b10000;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_ok;
    logic [31:0] rdata;
    logic        flush;
    logic [4:0]  ds_dest;
    logic [31:0] ds_value;
    logic        load_wait;
    logic        csr;
    logic        ex;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_if pipe ();

    mem_stage dut (
        .clk                (clk),
        .reset              (reset),
        .pipe               (pipe),
        .data_sram_data_ok  (data_ok),
        .data_sram_rdata    (rdata),
        .ws_reflush_ms      (flush),
        .ms_to_ds_dest      (ds_dest),
        .ms_to_ds_value     (ds_value),
        .ms_to_ds_load_wait (load_wait),
        .ms_csr             (csr),
        .ms_ex              (ex)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [167:0] got, input logic [167:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [174:0] mk(input logic mreq, input logic rfm, input logic [4:0] op,
                                        input logic [31:0] va, input logic [4:0] dst,
                                        input logic [31:0] fr);
        logic [174:0] b = {175{1'b0}};
        b[174]     = mreq;
        b[173]     = rfm;
        b[172:168] = op;
        b[167:136] = va;
        b[69]      = 1'b1;
        b[68:64]   = dst;
        b[63:32]   = fr;
        b[31:0]    = 32'h1c00_0040;
        return b;
    endfunction

    // Expected WB bus: load data picked by shifting the word down to the addressed lane.
    function automatic logic [167:0] exp_out(input logic [174:0] b, input logic [31:0] w);
        logic [167:0] o   = b[167:0];
        logic [1:0]   off = b[137:136];
        logic [31:0]  sb  = w >> (8 * off);
        logic [31:0]  sh  = w >> (16 * off[1]);
        if (b[173]) begin
            if (b[168])      o[63:32] = {{24{sb[7]}}, sb[7:0]};
            else if (b[169]) o[63:32] = {24'd0, sb[7:0]};
            else if (b[170]) o[63:32] = {{16{sh[15]}}, sh[15:0]};
            else if (b[171]) o[63:32] = {16'd0, sh[15:0]};
            else             o[63:32] = w;
        end
        return o;
    endfunction

    function automatic inst_t gen_inst();
        inst_t        t;
        int           kind = $urandom_range(0, 2);
        logic [191:0] r    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        t.bus[167:0]   = r[167:0];
        t.bus[174]     = (kind != 0);
        t.bus[173]     = (kind == 1);
        t.bus[172:168] = (kind == 1) ? 5'(5'b00001 << $urandom_range(0, 4)) : 5'd0;
        if (kind != 0 || $urandom_range(0, 3) != 0) begin
            t.bus[86:70] = 17'd0;
            t.bus[135]   = 1'b0;
        end
        t.data = $urandom;
        t.got  = 1'b0;
        return t;
    endfunction

    task automatic load_now(input string tag, input logic [4:0] op, input logic [31:0] va,
                            input logic [31:0] word, input logic [31:0] expv);
        pipe.es_to_ms_valid = 1'b1;
        pipe.es_to_ms_bus   = mk(1'b1, 1'b1, op, va, 5'd7, 32'h0);
        tick();
        pipe.es_to_ms_valid = 1'b0;
        data_ok = 1'b1;
        rdata   = word;
        @(negedge clk);
        check_eq({tag, "_valid"}, 168'(pipe.ms_to_ws_valid), 168'(1'b1));
        check_eq(tag, 168'(pipe.ms_to_ws_bus[63:32]), 168'(expv));
        tick();
        data_ok = 1'b0;
    endtask

    task automatic run_random(input int cycles);
        resp_t rq[$];
        inst_t cur;
        inst_t nxt;
        logic  in_ms    = 1'b0;
        logic  have_nxt = 1'b0;
        int    drops    = 0;
        logic  do_flush, dok_alive, exp_v, exp_allow, ret, cap;
        logic [4:0]   exp_dest;
        logic [167:0] eo;
        cur = gen_inst();
        nxt = cur;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            if (!have_nxt && $urandom_range(0, 3) != 0) begin
                nxt      = gen_inst();
                have_nxt = 1'b1;
            end
            do_flush = in_ms && (drops < 2) && ($urandom_range(0, 11) == 0);
            flush    = do_flush;
            pipe.es_to_ms_valid = have_nxt && !do_flush;
            pipe.es_to_ms_bus   = nxt.bus;
            pipe.ws_allowin     = !do_flush && ($urandom_range(0, 3) != 0);
            if (rq.size() > 0 && rq[0].ready <= cyc) begin
                data_ok   = 1'b1;
                rdata     = rq[0].data;
                dok_alive = rq[0].alive;
            end else begin
                data_ok   = 1'b0;
                rdata     = $urandom;
                dok_alive = 1'b0;
            end
            exp_v     = in_ms && (!cur.bus[174] || cur.got || dok_alive);
            exp_allow = !in_ms || (exp_v && pipe.ws_allowin);
            exp_dest  = (in_ms && cur.bus[69]) ? cur.bus[68:64] : 5'd0;
            @(negedge clk);
            check_eq("r_valid", 168'(pipe.ms_to_ws_valid), 168'(exp_v));
            check_eq("r_allowin", 168'(pipe.ms_allowin), 168'(exp_allow));
            check_eq("r_load_wait", 168'(load_wait), 168'(in_ms && cur.bus[173] && !exp_v));
            check_eq("r_dest", 168'(ds_dest), 168'(exp_dest));
            check_eq("r_csr", 168'(csr), 168'(in_ms && (cur.bus[134] || cur.bus[133])));
            check_eq("r_ex", 168'(ex), 168'(in_ms && (cur.bus[135] || cur.bus[86:70] != 17'd0)));
            ret = exp_v && pipe.ws_allowin;
            if (ret) begin
                eo = exp_out(cur.bus, cur.data);
                check_eq("r_bus", pipe.ms_to_ws_bus, eo);
                check_eq("r_value", 168'(ds_value), 168'((exp_dest != 5'd0) ? eo[63:32] : 32'd0));
            end
            if (data_ok) begin
                if (!rq[0].alive) drops--;
                else cur.got = 1'b1;
                void'(rq.pop_front());
            end
            if (do_flush) begin
                if (cur.bus[174] && !cur.got) begin
                    rq[rq.size() - 1].alive = 1'b0;
                    drops++;
                end
                in_ms = 1'b0;
            end else if (ret) begin
                in_ms = 1'b0;
            end
            cap = pipe.es_to_ms_valid && exp_allow;
            if (cap) begin
                cur      = nxt;
                cur.got  = 1'b0;
                in_ms    = 1'b1;
                have_nxt = 1'b0;
                if (cur.bus[174]) rq.push_back('{cyc + 1 + $urandom_range(0, 3), cur.data, 1'b1});
            end
            tick();
        end
        flush = 1'b0;
        pipe.es_to_ms_valid = 1'b0;
        data_ok = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        data_ok = 1'b0;
        rdata = 32'd0;
        pipe.es_to_ms_valid = 1'b0;
        pipe.es_to_ms_bus   = {175{1'b0}};
        pipe.ws_allowin     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_to_ws_valid", 168'(pipe.ms_to_ws_valid), 168'(1'b0));
        check_eq("rst_allowin", 168'(pipe.ms_allowin), 168'(1'b1));
        check_eq("rst_dest", 168'(ds_dest), 168'(5'd0));
        check_eq("rst_load_wait", 168'(load_wait), 168'(1'b0));
        check_eq("rst_csr", 168'(csr), 168'(1'b0));
        check_eq("rst_ex", 168'(ex), 168'(1'b0));
        tick();

        // ALU instruction: one cycle in MS, bus forwarded unchanged
        pipe.es_to_ms_valid = 1'b1;
        pipe.es_to_ms_bus   = mk(1'b0, 1'b0, 5'd0, 32'h0000_1000, 5'd5, 32'h0000_1234);
        tick();
        pipe.es_to_ms_valid = 1'b0;
        @(negedge clk);
        check_eq("alu_valid", 168'(pipe.ms_to_ws_valid), 168'(1'b1));
        check_eq("alu_bus", pipe.ms_to_ws_bus,
                 mk(1'b0, 1'b0, 5'd0, 32'h0000_1000, 5'd5, 32'h0000_1234) & {7'd0, {168{1'b1}}});
        check_eq("alu_dest", 168'(ds_dest), 168'(5'd5));
        check_eq("alu_value", 168'(ds_value), 168'(32'h0000_1234));
        tick();
        @(negedge clk);
        check_eq("alu_gone", 168'(pipe.ms_to_ws_valid), 168'(1'b0));
        tick();

        load_now("ld_b", LD_B, 32'h0000_0013, 32'h80FF_1234, 32'hFFFF_FF80);
        load_now("ld_hu", LD_HU, 32'h0000_0022, 32'h80FF_1234, 32'h0000_80FF);
        load_now("ld_h", LD_H, 32'h0000_0030, 32'h80FF_1234, 32'h0000_1234);
        load_now("ld_w", LD_W, 32'h0000_0040, 32'h80FF_1234, 32'h80FF_1234);
        load_now("ld_bu", LD_BU, 32'h0000_0011, 32'h80FF_1234, 32'h0000_0012);

        // Load whose response arrives three cycles after capture
        pipe.es_to_ms_valid = 1'b1;
        pipe.es_to_ms_bus   = mk(1'b1, 1'b1, LD_W, 32'h0, 5'd7, 32'h0);
        tick();
        pipe.es_to_ms_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("wait_valid", 168'(pipe.ms_to_ws_valid), 168'(1'b0));
            check_eq("wait_load_wait", 168'(load_wait), 168'(1'b1));
            check_eq("wait_allowin", 168'(pipe.ms_allowin), 168'(1'b0));
            tick();
        end
        data_ok = 1'b1;
        rdata   = 32'h89AB_CDEF;
        @(negedge clk);
        check_eq("wait_done_valid", 168'(pipe.ms_to_ws_valid), 168'(1'b1));
        check_eq("wait_done_data", 168'(pipe.ms_to_ws_bus[63:32]), 168'(32'h89AB_CDEF));
        tick();
        data_ok = 1'b0;

        // Response buffered while WB stalls
        pipe.es_to_ms_valid = 1'b1;
        pipe.es_to_ms_bus   = mk(1'b1, 1'b1, LD_W, 32'h0, 5'd7, 32'h0);
        tick();
        pipe.es_to_ms_valid = 1'b0;
        pipe.ws_allowin = 1'b0;
        data_ok = 1'b1;
        rdata   = 32'hCAFE_F00D;
        @(negedge clk);
        check_eq("buf_valid0", 168'(pipe.ms_to_ws_valid), 168'(1'b1));
        tick();
        data_ok = 1'b0;
        rdata   = 32'h1111_1111;
        @(negedge clk);
        check_eq("buf_valid1", 168'(pipe.ms_to_ws_valid), 168'(1'b1));
        check_eq("buf_data1", 168'(pipe.ms_to_ws_bus[63:32]), 168'(32'hCAFE_F00D));
        check_eq("buf_allowin1", 168'(pipe.ms_allowin), 168'(1'b0));
        tick();
        pipe.ws_allowin = 1'b1;
        rdata = 32'h2222_2222;
        @(negedge clk);
        check_eq("buf_data2", 168'(pipe.ms_to_ws_bus[63:32]), 168'(32'hCAFE_F00D));
        check_eq("buf_allowin2", 168'(pipe.ms_allowin), 168'(1'b1));
        tick();
        @(negedge clk);
        check_eq("buf_gone", 168'(pipe.ms_to_ws_valid), 168'(1'b0));
        tick();

        // Flush with a pending load: the next load must skip one stale response
        pipe.es_to_ms_valid = 1'b1;
        pipe.es_to_ms_bus   = mk(1'b1, 1'b1, LD_W, 32'h0, 5'd7, 32'h0);
        tick();
        pipe.es_to_ms_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        pipe.es_to_ms_valid = 1'b1;
        @(negedge clk);
        check_eq("fl_empty_valid", 168'(pipe.ms_to_ws_valid), 168'(1'b0));
        check_eq("fl_empty_allowin", 168'(pipe.ms_allowin), 168'(1'b1));
        tick();
        pipe.es_to_ms_valid = 1'b0;
        data_ok = 1'b1;
        rdata   = 32'h0000_DEAD;
        @(negedge clk);
        check_eq("fl_stale_valid", 168'(pipe.ms_to_ws_valid), 168'(1'b0));
        check_eq("fl_stale_wait", 168'(load_wait), 168'(1'b1));
        tick();
        rdata = 32'h0000_0BEE;
        @(negedge clk);
        check_eq("fl_real_valid", 168'(pipe.ms_to_ws_valid), 168'(1'b1));
        check_eq("fl_real_data", 168'(pipe.ms_to_ws_bus[63:32]), 168'(32'h0000_0BEE));
        tick();
        data_ok = 1'b0;
        load_now("fl_after", LD_W, 32'h0, 32'h0000_4444, 32'h0000_4444);

        // Flush coinciding with the owned response must not arm a discard
        pipe.es_to_ms_valid = 1'b1;
        pipe.es_to_ms_bus   = mk(1'b1, 1'b1, LD_W, 32'h0, 5'd7, 32'h0);
        tick();
        pipe.es_to_ms_valid = 1'b0;
        flush = 1'b1;
        data_ok = 1'b1;
        rdata = 32'h0000_5555;
        pipe.ws_allowin = 1'b0;
        tick();
        flush = 1'b0;
        data_ok = 1'b0;
        pipe.ws_allowin = 1'b1;
        load_now("fl_same", LD_W, 32'h0, 32'h0000_7777, 32'h0000_7777);

        // Reset during an outstanding discard clears it
        pipe.es_to_ms_valid = 1'b1;
        pipe.es_to_ms_bus   = mk(1'b1, 1'b1, LD_W, 32'h0, 5'd7, 32'h0);
        tick();
        pipe.es_to_ms_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load_now("rst_drop", LD_W, 32'h0, 32'h0000_3333, 32'h0000_3333);

        run_random(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
